// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, one bit per clock; SERIAL_ADD_OVF_EN adds port ovf.
// Latency WIDTH cycles from accept to the done pulse; start is ignored (not queued) while busy.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             ha0_s, ha0_c, fa_s, ha1_c, fa_c;
  logic [WIDTH:0]   acc_shift;

  // Full adder as two half adders on the operand LSBs and the carry flop.
  assign ha0_s = a_q[0] ^ b_q[0];
  assign ha0_c = a_q[0] & b_q[0];
  assign fa_s  = ha0_s ^ carry_q;
  assign ha1_c = ha0_s & carry_q;
  assign fa_c  = ha0_c | ha1_c;

  assign acc_shift = {fa_s, acc_q};

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_shift[WIDTH:1];
        carry_d = fa_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB here, fa_c the carry out of it.
          sum_d   = acc_shift[WIDTH:1];
          cout_d  = fa_c;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8, 4 and 1; ovf checked when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       st8, st4, st1;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic [0:0] a1, b1;
  logic       ci8, ci4, ci1;
  logic       busy8, busy4, busy1;
  logic       done8, done4, done1;
  logic [7:0] sum8;
  logic [3:0] sum4;
  logic [0:0] sum1;
  logic       co8, co4, co1;
  logic       ov8, ov4, ov1;

  serial_adder_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(co8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ov8)
`endif
  );
  serial_adder_ctrl #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(ci4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(co4)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ov4)
`endif
  );
  serial_adder_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(co1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ov1)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ov8 = 1'b0;
  assign ov4 = 1'b0;
  assign ov1 = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q8[$], q4[$], q1[$];
  int   bc8 = 0, bc4 = 0, bc1 = 0;
  int   nd8 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition of w-bit operands; ovf from operand/result sign bits.
  function automatic exp_t model(input int w, input logic [7:0] av, input logic [7:0] bv, input logic c);
    exp_t       e;
    logic [8:0] m;
    logic [8:0] full;
    m    = (9'd1 << w) - 9'd1;
    full = ({1'b0, av} & m) + ({1'b0, bv} & m) + {8'd0, c};
    e.sum  = full[7:0] & m[7:0];
    e.cout = full[w];
    e.ovf  = (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic check_done(input string tag, input int w, input exp_t e, input logic [7:0] s,
                            input logic co, input logic ov, input logic bsy, input int bc);
    chk({tag, "_sum"}, {24'd0, s}, {24'd0, e.sum});
    chk({tag, "_cout"}, {31'd0, co}, {31'd0, e.cout});
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ov}, {31'd0, e.ovf});
`else
    if (ov !== 1'b0) chk({tag, "_ovf_tie"}, {31'd0, ov}, 32'd0);
`endif
    chk({tag, "_latency"}, cyc - e.cyc, w);
    chk({tag, "_busy_cycles"}, bc, w);
    chk({tag, "_busy_at_done"}, {31'd0, bsy}, 32'd0);
  endtask

  task automatic unexpected(input string tag);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_done actual=done required=no_done (t=%0t)", tag, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) bc8 = 0;
    else begin
      if (busy8) bc8++;
      if (done8) begin
        nd8++;
        if (q8.size() == 0) unexpected("w8");
        else check_done("w8", 8, q8.pop_front(), sum8, co8, ov8, busy8, bc8);
        bc8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) bc4 = 0;
    else begin
      if (busy4) bc4++;
      if (done4) begin
        if (q4.size() == 0) unexpected("w4");
        else check_done("w4", 4, q4.pop_front(), {4'd0, sum4}, co4, ov4, busy4, bc4);
        bc4 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) bc1 = 0;
    else begin
      if (busy1) bc1++;
      if (done1) begin
        if (q1.size() == 0) unexpected("w1");
        else check_done("w1", 1, q1.pop_front(), {7'd0, sum1}, co1, ov1, busy1, bc1);
        bc1 = 0;
      end
    end
  end

  // Drives one request; the next rising edge is the accepting edge.
  task automatic issue(input int w, input logic [7:0] av, input logic [7:0] bv, input logic c);
    exp_t e;
    e = model(w, av, bv, c);
    case (w)
      8:       begin st8 = 1'b1; a8 = av;      b8 = bv;      ci8 = c; end
      4:       begin st4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; ci4 = c; end
      default: begin st1 = 1'b1; a1 = av[0];   b1 = bv[0];   ci1 = c; end
    endcase
    @(posedge clk);
    #1;
    e.cyc = cyc;
    case (w)
      8:       begin q8.push_back(e); st8 = 1'b0; a8 = ~av;      b8 = ~bv;      ci8 = ~c; end
      4:       begin q4.push_back(e); st4 = 1'b0; a4 = ~av[3:0]; b4 = ~bv[3:0]; ci4 = ~c; end
      default: begin q1.push_back(e); st1 = 1'b0; a1 = ~av[0];   b1 = ~bv[0];   ci1 = ~c; end
    endcase
  endtask

  task automatic wait_done(input int w);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * w + 20 && !seen; i++) begin
      @(negedge clk);
      case (w)
        8:       seen = done8;
        4:       seen = done4;
        default: seen = done1;
      endcase
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_w%0d actual=no_done required=done", w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd;
    rst_n = 1'b1;
    st8 = 0; st4 = 0; st1 = 0;
    a8 = 0; b8 = 0; a4 = 0; b4 = 0; a1 = 0; b1 = 0;
    ci8 = 0; ci4 = 0; ci1 = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, co8}, 32'd0);
    chk("rst_ovf", {31'd0, ov8}, 32'd0);
    chk("rst_busy4_busy1", {30'd0, busy4, busy1}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_done", nd8, 0);

    issue(8, 8'h35, 8'h4A, 1'b1);
    wait_done(8);
    issue(8, 8'hFF, 8'h00, 1'b1);
    wait_done(8);
    issue(8, 8'hFF, 8'hFF, 1'b1);
    wait_done(8);

    // Start during RUN must be ignored; a start in the done cycle is accepted.
    issue(8, 8'h01, 8'h02, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    st8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    wait_done(8);
    issue(8, 8'h10, 8'h20, 1'b0);
    wait_done(8);

    // Reset in the middle of an operation abandons it.
    issue(8, 8'hF0, 8'h0F, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q8.delete();
    #1;
    chk("midrst_busy", {31'd0, busy8}, 32'd0);
    chk("midrst_sum", {24'd0, sum8}, 32'd0);
    chk("midrst_cout", {31'd0, co8}, 32'd0);
    chk("midrst_done", {31'd0, done8}, 32'd0);
    nd = nd8;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", nd8, nd);
    issue(8, 8'h12, 8'h34, 1'b1);
    wait_done(8);

    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++) begin
          issue(1, 8'(x), 8'(y), c[0]);
          wait_done(1);
        end

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          issue(4, 8'(x), 8'(y), c[0]);
          wait_done(4);
        end

    repeat (5) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
